// File: rtl/led_pwm_pio_if.sv
// Avalon-MM slave bus bundle for the LED PWM PIO.
// The master drives address and write strobes; the slave returns combinational readdata.
interface led_pwm_pio_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;

  modport master (
    output address,
    output chipselect,
    output write_n,
    output writedata,
    input  readdata
  );

  modport slave (
    input  address,
    input  chipselect,
    input  write_n,
    input  writedata,
    output readdata
  );
endinterface

// File: rtl/led_pwm_pio.sv
// LED output PIO with atomic set/clear, global PWM brightness and per-bit blink.
// With reset-default DUTY (all ones) and MODE (zero) it behaves as a plain
// registered output port that follows DATA with one clock of latency.
module led_pwm_pio #(
  parameter int                 WIDTH       = 8,
  parameter int                 PWM_BITS    = 8,
  parameter int                 PRESCALE_W  = 16,
  parameter logic [WIDTH-1:0]   RESET_VALUE = '0
) (
  input  logic               clk,
  input  logic               reset_n,
  led_pwm_pio_if.slave       bus,
  output logic [WIDTH-1:0]   out_port
);

  localparam logic [2:0] ADDR_DATA     = 3'd0;
  localparam logic [2:0] ADDR_MODE     = 3'd1;
  localparam logic [2:0] ADDR_PRESCALE = 3'd2;
  localparam logic [2:0] ADDR_DUTY     = 3'd3;
  localparam logic [2:0] ADDR_OUTSET   = 3'd4;
  localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
  localparam logic [2:0] ADDR_STATUS   = 3'd6;

  localparam logic [PRESCALE_W-1:0] PRESC_ONE = 1;
  localparam logic [PWM_BITS-1:0]   PWM_ONE   = 1;

  // Programmable registers
  logic [WIDTH-1:0]      data_q, data_d;
  logic [WIDTH-1:0]      mode_q, mode_d;
  logic [PRESCALE_W-1:0] prescale_q, prescale_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;

  // Timebase state
  logic [PRESCALE_W-1:0] presc_cnt_q, presc_cnt_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  blink_q, blink_d;

  // Output stage
  logic [WIDTH-1:0]      out_q, out_d;

  logic                  wr_en;
  logic                  presc_wr;
  logic                  tick;
  logic                  pwm_wrap;
  logic                  pwm_on;
  logic [WIDTH-1:0]      wd_bits;
  logic [31:0]           rdata;
  logic                  unused_wd;

  assign wr_en     = bus.chipselect && !bus.write_n;
  assign presc_wr  = wr_en && (bus.address == ADDR_PRESCALE);
  assign wd_bits   = bus.writedata[WIDTH-1:0];
  // Upper writedata bits are intentionally ignored for narrow registers.
  assign unused_wd = ^bus.writedata;

  // Register file update: plain writes plus atomic set/clear of DATA
  always_comb begin
    data_d     = data_q;
    mode_d     = mode_q;
    prescale_d = prescale_q;
    duty_d     = duty_q;
    if (wr_en) begin
      case (bus.address)
        ADDR_DATA:     data_d     = wd_bits;
        ADDR_MODE:     mode_d     = wd_bits;
        ADDR_PRESCALE: prescale_d = bus.writedata[PRESCALE_W-1:0];
        ADDR_DUTY:     duty_d     = bus.writedata[PWM_BITS-1:0];
        ADDR_OUTSET:   data_d     = data_q | wd_bits;
        ADDR_OUTCLEAR: data_d     = data_q & ~wd_bits;
        default:       ;
      endcase
    end
  end

  // Prescaler: tick when the count reaches the reload value; a reload write restarts it silently
  always_comb begin
    tick        = !presc_wr && (presc_cnt_q == prescale_q);
    presc_cnt_d = (presc_wr || tick) ? '0 : presc_cnt_q + PRESC_ONE;
  end

  // PWM counter advances on tick; blink phase flips each time the counter wraps
  always_comb begin
    pwm_wrap  = tick && (pwm_cnt_q == {PWM_BITS{1'b1}});
    pwm_cnt_d = tick ? pwm_cnt_q + PWM_ONE : pwm_cnt_q;
    blink_d   = blink_q ^ pwm_wrap;
  end

  // Full-scale duty is forced on so there is no one-slot dark gap per PWM period
  always_comb begin
    pwm_on = (duty_q == {PWM_BITS{1'b1}}) || (pwm_cnt_q < duty_q);
  end

  // Per-LED gating: DATA, global PWM, and blink phase for LEDs in blink mode
  for (genvar gi = 0; gi < WIDTH; gi++) begin : g_led
    assign out_d[gi] = data_q[gi] & pwm_on & (mode_q[gi] ? blink_q : 1'b1);
  end

  // Read mux, combinational and side-effect free; write-only and reserved slots read zero
  always_comb begin
    rdata = '0;
    case (bus.address)
      ADDR_DATA:     rdata[WIDTH-1:0]      = data_q;
      ADDR_MODE:     rdata[WIDTH-1:0]      = mode_q;
      ADDR_PRESCALE: rdata[PRESCALE_W-1:0] = prescale_q;
      ADDR_DUTY:     rdata[PWM_BITS-1:0]   = duty_q;
      ADDR_STATUS:   rdata[PWM_BITS:0]     = {blink_q, pwm_cnt_q};
      default:       rdata                 = '0;
    endcase
  end

  assign bus.readdata = rdata;
  assign out_port     = out_q;

  // State registers with asynchronous clear
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_q      <= RESET_VALUE;
      mode_q      <= '0;
      prescale_q  <= '0;
      duty_q      <= '1;
      presc_cnt_q <= '0;
      pwm_cnt_q   <= '0;
      blink_q     <= 1'b0;
      out_q       <= '0;
    end else begin
      data_q      <= data_d;
      mode_q      <= mode_d;
      prescale_q  <= prescale_d;
      duty_q      <= duty_d;
      presc_cnt_q <= presc_cnt_d;
      pwm_cnt_q   <= pwm_cnt_d;
      blink_q     <= blink_d;
      out_q       <= out_d;
    end
  end

endmodule

// File: tb/tb_led_pwm_pio.sv
// Self-checking bench for led_pwm_pio: register table plus PWM/blink/prescaler/reset sequences.
module tb_led_pwm_pio;
  localparam int WIDTH      = 8;
  localparam int PWM_BITS   = 8;
  localparam int PRESCALE_W = 16;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [WIDTH-1:0] out_port;
  int               checks = 0;
  int               failures = 0;

  always #5 clk = ~clk;

  led_pwm_pio_if bus();

  led_pwm_pio #(
    .WIDTH(WIDTH), .PWM_BITS(PWM_BITS), .PRESCALE_W(PRESCALE_W), .RESET_VALUE(8'h00)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus), .out_port(out_port)
  );

  typedef enum logic [1:0] {OP_WR, OP_RD, OP_OUT, OP_NOW} op_e;
  typedef struct {
    op_e         op;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end else begin
      $display("ok   %s value=0x%0h", name, act);
    end
  endtask

  task automatic bus_write(input logic [2:0] a, input logic [31:0] d);
    @(negedge clk);
    bus.address    = a;
    bus.writedata  = d;
    bus.chipselect = 1'b1;
    bus.write_n    = 1'b0;
    @(posedge clk);
    #1;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    $display("wr   addr=%0d data=0x%0h", a, d);
  endtask

  task automatic bus_read(input logic [2:0] a, output logic [31:0] d);
    bus.address = a;
    #1;
    d = bus.readdata;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic [31:0] v0;
    logic [7:0]  prev_out, first_out, prev_st;
    int on_cnt, other_cnt, trans, bad, n;
    logic found, mid_hi, mid_lo;

    bus.address    = 3'd0;
    bus.chipselect = 1'b0;
    bus.write_n    = 1'b1;
    bus.writedata  = '0;

    // ---------------- reset state ----------------
    reset_n = 1'b0;
    #12;
    check("rst_out", {24'h0, out_port}, 32'h0);
    bus_read(3'd0, rd); check("rst_data", rd, 32'h0);
    bus_read(3'd3, rd); check("rst_duty", rd, 32'hFF);
    bus_read(3'd6, rd); check("rst_status", rd, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;

    // ---------------- table of register transactions ----------------
    vecs.push_back('{OP_WR,  3'd0, 32'hA5,       32'h0});
    vecs.push_back('{OP_NOW, 3'd0, 32'h0,        32'h00});
    vecs.push_back('{OP_OUT, 3'd0, 32'h0,        32'hA5});
    vecs.push_back('{OP_RD,  3'd0, 32'h0,        32'hA5});
    vecs.push_back('{OP_WR,  3'd0, 32'h0F,       32'h0});
    vecs.push_back('{OP_WR,  3'd4, 32'h30,       32'h0});
    vecs.push_back('{OP_RD,  3'd0, 32'h0,        32'h3F});
    vecs.push_back('{OP_WR,  3'd5, 32'h05,       32'h0});
    vecs.push_back('{OP_RD,  3'd0, 32'h0,        32'h3A});
    vecs.push_back('{OP_RD,  3'd4, 32'h0,        32'h0});
    vecs.push_back('{OP_RD,  3'd5, 32'h0,        32'h0});
    vecs.push_back('{OP_OUT, 3'd0, 32'h0,        32'h3A});
    vecs.push_back('{OP_RD,  3'd1, 32'h0,        32'h0});
    vecs.push_back('{OP_RD,  3'd2, 32'h0,        32'h0});
    vecs.push_back('{OP_RD,  3'd3, 32'h0,        32'hFF});
    vecs.push_back('{OP_RD,  3'd7, 32'h0,        32'h0});
    vecs.push_back('{OP_WR,  3'd7, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{OP_RD,  3'd0, 32'h0,        32'h3A});
    vecs.push_back('{OP_RD,  3'd1, 32'h0,        32'h0});
    vecs.push_back('{OP_RD,  3'd2, 32'h0,        32'h0});
    vecs.push_back('{OP_RD,  3'd3, 32'h0,        32'hFF});
    vecs.push_back('{OP_RD,  3'd7, 32'h0,        32'h0});
    vecs.push_back('{OP_WR,  3'd1, 32'h81,       32'h0});
    vecs.push_back('{OP_RD,  3'd1, 32'h0,        32'h81});
    vecs.push_back('{OP_OUT, 3'd0, 32'h0,        32'h3A});
    vecs.push_back('{OP_WR,  3'd1, 32'h0,        32'h0});
    vecs.push_back('{OP_WR,  3'd3, 32'h1FF,      32'h0});
    vecs.push_back('{OP_RD,  3'd3, 32'h0,        32'hFF});
    vecs.push_back('{OP_WR,  3'd0, 32'h1A5,      32'h0});
    vecs.push_back('{OP_RD,  3'd0, 32'h0,        32'hA5});
    vecs.push_back('{OP_WR,  3'd2, 32'h12345,    32'h0});
    vecs.push_back('{OP_RD,  3'd2, 32'h0,        32'h2345});
    vecs.push_back('{OP_WR,  3'd2, 32'h0,        32'h0});

    foreach (vecs[i]) begin
      case (vecs[i].op)
        OP_WR:  bus_write(vecs[i].addr, vecs[i].data);
        OP_RD: begin
          bus_read(vecs[i].addr, rd);
          check($sformatf("vec%0d_rd%0d", i, vecs[i].addr), rd, vecs[i].exp);
        end
        OP_OUT: begin
          step();
          check($sformatf("vec%0d_out", i), {24'h0, out_port}, vecs[i].exp);
        end
        default: check($sformatf("vec%0d_now", i), {24'h0, out_port}, vecs[i].exp);
      endcase
    end

    // ---------------- PWM duty 0x40: 64 of 256 clocks on ----------------
    bus_write(3'd0, 32'hFF);
    bus_write(3'd3, 32'h40);
    bus.address = 3'd6;
    step();
    step();
    on_cnt = 0; other_cnt = 0; trans = 0; bad = 0;
    first_out = out_port; prev_out = out_port; prev_st = bus.readdata[7:0];
    if (out_port == 8'hFF) on_cnt++; else if (out_port != 8'h00) other_cnt++;
    for (int k = 1; k < 256; k++) begin
      step();
      if (out_port == 8'hFF) on_cnt++; else if (out_port != 8'h00) other_cnt++;
      if (out_port != prev_out) trans++;
      if (8'(bus.readdata[7:0] - prev_st) != 8'd1) bad++;
      prev_out = out_port;
      prev_st  = bus.readdata[7:0];
    end
    if (prev_out != first_out) trans++;
    check("pwm40_on_slots", on_cnt, 64);
    check("pwm40_other", other_cnt, 0);
    check("pwm40_edges", trans, 2);
    check("pwm40_cnt_steps", bad, 0);

    bus_write(3'd3, 32'h00);
    step();
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (out_port != 8'h00) bad++;
    end
    check("pwm00_nonzero", bad, 0);

    bus_write(3'd3, 32'hFF);
    step();
    bad = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (out_port != 8'hFF) bad++;
    end
    check("pwmFF_gaps", bad, 0);

    // ---------------- blink: PRESCALE=3, MODE=0x01, DATA=0x03 ----------------
    @(negedge clk); reset_n = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    bus_write(3'd2, 32'h3);
    bus_write(3'd1, 32'h01);
    bus_write(3'd0, 32'h03);
    step();
    check("blink_start", {24'h0, out_port}, 32'h02);
    bus.address = 3'd6;
    found = 1'b0; bad = 0;
    for (int k = 0; k < 3000; k++) begin
      step();
      if (!out_port[1]) bad++;
      if (out_port[0]) begin
        found = 1'b1;
        break;
      end
    end
    check("blink_rise_seen", {31'h0, found}, 32'h1);
    n = 0; mid_hi = 1'b0;
    while (out_port[0] && n < 3000) begin
      step();
      n++;
      if (!out_port[1]) bad++;
      if (n == 512) mid_hi = bus.readdata[8];
    end
    check("blink_high_len", n, 1024);
    n = 0; mid_lo = 1'b1;
    while (!out_port[0] && n < 3000) begin
      step();
      n++;
      if (!out_port[1]) bad++;
      if (n == 512) mid_lo = bus.readdata[8];
    end
    check("blink_low_len", n, 1024);
    check("blink_phase_hi", {31'h0, mid_hi}, 32'h1);
    check("blink_phase_lo", {31'h0, mid_lo}, 32'h0);
    check("blink_bit1_gaps", bad, 0);

    // ---------------- PRESCALE rewrite mid-count ----------------
    step();
    step();
    bus_write(3'd2, 32'h9);
    bus.address = 3'd6;
    #1;
    v0 = bus.readdata;
    bad = 0;
    for (int k = 1; k < 30; k++) begin
      step();
      if (bus.readdata[7:0] != 8'(v0[7:0] + 8'(k / 10))) bad++;
      if (k == 9)  check("presc9_before_tick", {24'h0, bus.readdata[7:0]}, {24'h0, v0[7:0]});
      if (k == 10) check("presc9_first_tick", {24'h0, bus.readdata[7:0]}, {24'h0, 8'(v0[7:0] + 8'd1)});
    end
    check("presc9_steps", bad, 0);

    // ---------------- asynchronous reset mid-blink ----------------
    check("prereset_bit1", {31'h0, out_port[1]}, 32'h1);
    #3;
    reset_n = 1'b0;
    #1;
    check("arst_out", {24'h0, out_port}, 32'h0);
    bus_read(3'd6, rd); check("arst_status", rd, 32'h0);
    bus_read(3'd0, rd); check("arst_data", rd, 32'h0);
    bus_read(3'd1, rd); check("arst_mode", rd, 32'h0);
    bus_read(3'd2, rd); check("arst_prescale", rd, 32'h0);
    bus_read(3'd3, rd); check("arst_duty", rd, 32'hFF);
    @(negedge clk);
    reset_n = 1'b1;
    bus.address = 3'd6;
    step();
    check("restart_cnt1", bus.readdata, 32'h1);
    step();
    check("restart_cnt2", bus.readdata, 32'h2);
    check("restart_out", {24'h0, out_port}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
